// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS32 CPU: multiply/divide opcodes, unit states and
// a magnitude helper used when latching signed operands.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude when the operand is treated as signed.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] val, input logic sgn);
        return (sgn && val[31]) ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial product high, multiplier bits still to consume}.
// Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
module mips_cpu_muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] partial;
    logic        fits;
    logic [31:0] rem_sub;

    // Conditional add-and-shift for multiply, trial-subtract-and-shift for divide.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        partial  = {acc[63:32], acc[31]};
        fits     = (partial >= {1'b0, opnd});
        // The true difference is below the divisor, so 32 bits suffice.
        rem_sub  = partial[31:0] - opnd;
        acc_next = 64'd0;
        if (!is_div) begin
            acc_next = {sum, acc[31:1]};
        end else if (fits) begin
            acc_next = {rem_sub, acc[30:0], 1'b1};
        end else begin
            acc_next = {partial[31:0], acc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | accepts start; MTHI/MTLO write HI/LO directly from here
//   RUN   | ITER radix-2 iterations on operand magnitudes
//   FIX   | sign correction, special cases, HI/LO write
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    muldiv_state_t state_q, state_d;
    logic          accept, mt_hi, mt_lo, fin;

    logic [63:0] acc_q, acc_step, acc_init;
    logic [31:0] opnd_q, opnd_init, a_q;
    logic        div_q, neg_q, neg_rem_q;
    logic        is_signed, is_div;
    logic [4:0]  cnt_q;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    mips_cpu_muldiv_step u_step (
        .is_div   (div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            accept  = 1'b1;
                            state_d = RUN;
                        end
                        MD_MTHI: mt_hi = 1'b1;
                        MD_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes and initial accumulator loaded at acceptance.
    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV) || (op == MD_DIVU);
        a_mag     = mag32(a, is_signed);
        b_mag     = mag32(b, is_signed);
        if (is_div) begin
            acc_init  = {32'd0, a_mag};
            opnd_init = b_mag;
        end else begin
            acc_init  = {32'd0, b_mag};
            opnd_init = a_mag;
        end
    end

    // Final result with sign correction; divide by zero returns all-ones / dividend.
    always_comb begin
        prod   = neg_q ? (~acc_q + 64'd1) : acc_q;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_q) begin
            if (opnd_q == 32'd0) begin
                res_lo = 32'hFFFF_FFFF;
                res_hi = a_q;
            end else begin
                res_lo = neg_q     ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
                res_hi = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch, iteration accumulator and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            a_q       <= 32'd0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= 5'd0;
        end else if (accept) begin
            acc_q     <= acc_init;
            opnd_q    <= opnd_init;
            a_q       <= a;
            div_q     <= is_div;
            neg_q     <= is_signed && (a[31] ^ b[31]);
            neg_rem_q <= is_signed && a[31];
            cnt_q     <= 5'd0;
        end else if (state_q == RUN) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Architectural HI/LO: written at FIX exit or directly by MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (fin) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= fin;
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for the multiply/divide unit.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from just after a negedge; returns HI/LO in the done cycle.
    // With noise set, further start requests are driven during RUN.
    task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, output logic [31:0] rh, output logic [31:0] rl,
                          output logic [31:0] mid_lo, output int nbusy, output bit to);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        nbusy  = 0;
        to     = 1'b1;
        mid_lo = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (noise && i < 3) begin
                start = 1'b1;
                op    = (i == 2) ? MD_MULTU : MD_MTLO;
                a     = 32'h1;
                b     = 32'h3;
            end else begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (i == 16) mid_lo = lo;
            if (busy) nbusy++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = MD_MULT;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_multu();
        logic [31:0] rh, rl, ml;
        int nb;
        bit to;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to) begin errors++; $display("FAIL multu_timeout: got no done expected done"); end
        checks++;
        if (nb != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", nb); end
        checks++;
        if (ml !== 32'h0) begin errors++; $display("FAIL multu_lo_hold: got %h expected 00000000", ml); end
        checks++;
        if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", rh, rl);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_mult();
        logic [31:0] rh, rl, ml;
        int nb;
        bit to;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to || {rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg: got %h_%h to=%b expected ffffffff_ffffffeb", rh, rl, to);
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        logic [31:0] rh, rl, ml;
        int nb;
        bit to;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to || rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg: got hi=%h lo=%h to=%b expected hi=ffffffff lo=fffffffd", rh, rl, to);
        end
        @(negedge clk);
        run_op(MD_DIVU, 32'h0000_0064, 32'h0, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to || rl !== 32'hFFFF_FFFF || rh !== 32'h0000_0064) begin
            errors++;
            $display("FAIL divu_by_zero: got hi=%h lo=%h to=%b expected hi=00000064 lo=ffffffff", rh, rl, to);
        end
        @(negedge clk);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to || rl !== 32'h8000_0000 || rh !== 32'h0) begin
            errors++;
            $display("FAIL div_overflow: got hi=%h lo=%h to=%b expected hi=00000000 lo=80000000", rh, rl, to);
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1;
        op    = MD_MTHI;
        a     = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h busy=%b expected hi=12345678 busy=0", hi, busy);
        end
        op = MD_MTLO;
        a  = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h done=%b expected hi=12345678 lo=9abcdef0 done=0", hi, lo, done);
        end
        start = 1'b1;
        op    = muldiv_op_t'(3'd6);
        a     = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL op6_ignored: got busy=%b hi=%h lo=%h expected 0 12345678 9abcdef0", busy, hi, lo);
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [31:0] rh, rl, ml;
        int nb;
        bit to;
        run_op(MD_DIV, 32'd100, 32'd7, 1'b1, rh, rl, ml, nb, to);
        checks++;
        if (ml !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL busy_mtlo_ignored: got lo=%h expected 9abcdef0", ml);
        end
        checks++;
        if (to || nb != 33 || rl !== 32'd14 || rh !== 32'd2) begin
            errors++;
            $display("FAIL busy_div_result: got hi=%h lo=%h busy_cycles=%0d expected hi=2 lo=e busy_cycles=33", rh, rl, nb);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_not_queued: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL midrst_clear: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL midrst_discard: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl, ml;
        int nb;
        bit to;
        run_op(MD_MULTU, 32'd6, 32'd7, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (to || rl !== 32'd42 || rh !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first: got hi=%h lo=%h to=%b expected hi=0 lo=2a", rh, rl, to);
        end
        run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, rh, rl, ml, nb, to);
        checks++;
        if (nb != 33) begin
            errors++;
            $display("FAIL b2b_no_bubble: got busy_cycles=%0d expected 33", nb);
        end
        checks++;
        if (ml !== 32'd42) begin
            errors++;
            $display("FAIL b2b_lo_hold: got lo=%h expected 2a", ml);
        end
        checks++;
        if (to || rl !== 32'd15 || rh !== 32'd0) begin
            errors++;
            $display("FAIL b2b_second: got hi=%h lo=%h to=%b expected hi=0 lo=f", rh, rl, to);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
